// File: rtl/cdc_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ write-domain requesters.
// A grant is held for a burst ending on req_last_i or after MAX_BURST beats, followed by one idle cycle.
module cdc_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_we_o,
    output logic [DATA_WIDTH-1:0]         fifo_din_o,
    input  logic                          fifo_wrdy_i,
    output logic                          busy_o,
    output logic [ID_W-1:0]               grant_id_o
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, stateNext;
    logic [ID_W-1:0]  grantId, grantIdNext;
    logic [ID_W-1:0]  lastGrant, lastGrantNext;
    logic [CNT_W-1:0] beatCnt, beatCntNext;
    logic             anyReq;
    logic [ID_W-1:0]  pickIdx;
    logic [ID_W:0]    cand;
    logic             grantValid;
    logic             grantLast;
    logic             beatXfer;

    // Circular search starting just after the previous winner; the extra bit absorbs the wrap.
    always_comb begin
        anyReq  = 1'b0;
        pickIdx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, lastGrant} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!anyReq && req_valid_i[cand[ID_W-1:0]]) begin
                anyReq  = 1'b1;
                pickIdx = cand[ID_W-1:0];
            end
        end
    end

    assign grantValid = req_valid_i[grantId];
    assign grantLast  = req_last_i[grantId];
    assign beatXfer   = (state == BUSY) && grantValid && fifo_wrdy_i;

    always_comb begin
        stateNext     = state;
        grantIdNext   = grantId;
        lastGrantNext = lastGrant;
        beatCntNext   = beatCnt;
        busy_o        = (state == BUSY);
        grant_id_o    = grantId;
        fifo_we_o     = 1'b0;
        fifo_din_o    = '0;
        req_ready_o   = '0;

        case (state)
            IDLE: begin
                if (anyReq) begin
                    grantIdNext   = pickIdx;
                    lastGrantNext = pickIdx;
                    beatCntNext   = '0;
                    stateNext     = BUSY;
                end
            end
            BUSY: begin
                fifo_we_o  = grantValid;
                fifo_din_o = req_data_i[int'(grantId)*DATA_WIDTH +: DATA_WIDTH];
                for (int k = 0; k < NUM_REQ; k++) begin
                    req_ready_o[k] = fifo_wrdy_i && (grantId == ID_W'(k));
                end
                // Leaving on the final beat means the counter never has to wrap.
                if (beatXfer) begin
                    if (grantLast || (beatCnt == LAST_BEAT)) begin
                        stateNext = IDLE;
                    end else begin
                        beatCntNext = beatCnt + 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            grantId   <= '0;
            lastGrant <= LAST_IDX;
            beatCnt   <= '0;
        end else begin
            state     <= stateNext;
            grantId   <= grantIdNext;
            lastGrant <= lastGrantNext;
            beatCnt   <= beatCntNext;
        end
    end

endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// Scoreboard bench for cdc_wr_arbiter: instance 0 uses MAX_BURST=4, instance 1 uses MAX_BURST=1.
// Requester models drain per-requester beat queues; a monitor checks every FIFO write against expectations.
module tb_cdc_wr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  reqValid [2];
    logic [3:0]  reqLast  [2];
    logic [31:0] reqData  [2];
    logic [3:0]  reqReady [2];
    logic        fifoWe   [2];
    logic [7:0]  fifoDin  [2];
    logic        fifoWrdy [2];
    logic        busy     [2];
    logic [1:0]  grantId  [2];

    cdc_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dutA (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(reqValid[0]), .req_last_i(reqLast[0]), .req_data_i(reqData[0]),
        .req_ready_o(reqReady[0]), .fifo_we_o(fifoWe[0]), .fifo_din_o(fifoDin[0]),
        .fifo_wrdy_i(fifoWrdy[0]), .busy_o(busy[0]), .grant_id_o(grantId[0])
    );

    cdc_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dutB (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(reqValid[1]), .req_last_i(reqLast[1]), .req_data_i(reqData[1]),
        .req_ready_o(reqReady[1]), .fifo_we_o(fifoWe[1]), .fifo_din_o(fifoDin[1]),
        .fifo_wrdy_i(fifoWrdy[1]), .busy_o(busy[1]), .grant_id_o(grantId[1])
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       endB;
    } exp_t;

    exp_t       expQ  [2][$];
    logic [8:0] beatQ [2][4][$];
    logic [3:0] hold  [2];
    logic [3:0] fire  [2];
    logic       pendIdle [2];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Requester models: beat accepted when valid & ready seen mid-cycle, next beat presented after the edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            reqValid[i] = '0;
            reqLast[i]  = '0;
            reqData[i]  = '0;
            fire[i]     = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) fire[i] = reqValid[i] & reqReady[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (fire[i][k] && beatQ[i][k].size() > 0) void'(beatQ[i][k].pop_front());
                    if (!hold[i][k] && beatQ[i][k].size() > 0) begin
                        reqValid[i][k]        = 1'b1;
                        reqLast[i][k]         = beatQ[i][k][0][8];
                        reqData[i][k*8 +: 8]  = beatQ[i][k][0][7:0];
                    end else begin
                        reqValid[i][k] = 1'b0;
                        reqLast[i][k]  = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every accepted FIFO write must match the head of the expectation queue.
    initial begin
        exp_t e;
        pendIdle[0] = 1'b0;
        pendIdle[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (pendIdle[i]) begin
                    check("bubble_after_burst", 32'(busy[i]), 32'd0);
                    pendIdle[i] = 1'b0;
                end
                if (rst_n && fifoWe[i] && fifoWrdy[i]) begin
                    if (expQ[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat inst%0d: got id=%0d data=%0h expected none", i, grantId[i], fifoDin[i]);
                    end else begin
                        e = expQ[i].pop_front();
                        check("beat_id", 32'(grantId[i]), 32'(e.id));
                        check("beat_data", 32'(fifoDin[i]), 32'(e.data));
                        pendIdle[i] = e.endB;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int i, input int k, input logic [7:0] d, input logic l);
        beatQ[i][k].push_back({l, d});
    endtask

    task automatic expBeat(input int i, input int id, input logic [7:0] d, input logic e);
        expQ[i].push_back({id[1:0], d, e});
    endtask

    task automatic clearQueues();
        for (int i = 0; i < 2; i++) begin
            hold[i] = '0;
            for (int k = 0; k < 4; k++) beatQ[i][k].delete();
        end
    endtask

    task automatic waitBusy(input int i, output int n);
        n = 0;
        while (!busy[i] && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (!busy[i]) begin
            bad++;
            $display("FAIL wait_busy inst%0d: got busy=0 expected busy=1 within 20 cycles", i);
        end
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while ((expQ[0].size() != 0 || expQ[1].size() != 0 || busy[0] || busy[1]) && n < 400) begin
            tick();
            n++;
        end
        total++;
        if (n >= 400) begin
            bad++;
            $display("FAIL wait_done: got pending=%0d/%0d expected 0/0 within 400 cycles", expQ[0].size(), expQ[1].size());
        end
        tick();
        tick();
    endtask

    task automatic checkIdleOutputs(input int i, input string tag);
        check({tag, "_busy"},  32'(busy[i]),     32'd0);
        check({tag, "_grant"}, 32'(grantId[i]),  32'd0);
        check({tag, "_we"},    32'(fifoWe[i]),   32'd0);
        check({tag, "_ready"}, 32'(reqReady[i]), 32'd0);
        check({tag, "_din"},   32'(fifoDin[i]),  32'd0);
    endtask

    initial begin
        int n;
        fifoWrdy[0] = 1'b1;
        fifoWrdy[1] = 1'b1;
        clearQueues();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs(0, "reset_a");
        checkIdleOutputs(1, "reset_b");
        tick();
        rst_n = 1'b1;

        // Single requester 1, three beats, last on the third.
        push(0, 1, 8'hA1, 1'b0); push(0, 1, 8'hA2, 1'b0); push(0, 1, 8'hA3, 1'b1);
        expBeat(0, 1, 8'hA1, 1'b0); expBeat(0, 1, 8'hA2, 1'b0); expBeat(0, 1, 8'hA3, 1'b1);
        waitBusy(0, n);
        check("grant_latency", 32'(n), 32'd2);
        check("t1_grant", 32'(grantId[0]), 32'd1);
        @(negedge clk);
        check("t1_ready_onehot", 32'(reqReady[0]), 32'h2);
        waitDone();

        // All four requesters busy with no last: 4-beat bursts in order 0,1,2,3,0,1,2,3.
        tick();
        rst_n = 1'b0;
        clearQueues();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 8; b++) push(0, k, 8'(8'h80 + 16*k + b), 1'b0);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++)
                for (int b = 0; b < 4; b++) expBeat(0, k, 8'(8'h80 + 16*k + 4*r + b), (b == 3));
        waitDone();

        // Requester 2 stalled by the FIFO for 5 cycles on its second beat.
        push(0, 2, 8'hC0, 1'b0); push(0, 2, 8'hC1, 1'b0); push(0, 2, 8'hC2, 1'b1);
        expBeat(0, 2, 8'hC0, 1'b0); expBeat(0, 2, 8'hC1, 1'b0); expBeat(0, 2, 8'hC2, 1'b1);
        waitBusy(0, n);
        check("t3_grant", 32'(grantId[0]), 32'd2);
        tick();
        fifoWrdy[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_ready", 32'(reqReady[0]), 32'd0);
            check("stall_we", 32'(fifoWe[0]), 32'd1);
            check("stall_din", 32'(fifoDin[0]), 32'hC1);
            tick();
        end
        fifoWrdy[0] = 1'b1;
        waitDone();

        // Requester 0 pauses after its first beat while requester 3 waits.
        push(0, 0, 8'h50, 1'b0); push(0, 0, 8'h51, 1'b0); push(0, 0, 8'h52, 1'b1);
        expBeat(0, 0, 8'h50, 1'b0); expBeat(0, 0, 8'h51, 1'b0); expBeat(0, 0, 8'h52, 1'b1);
        expBeat(0, 3, 8'h70, 1'b0); expBeat(0, 3, 8'h71, 1'b1);
        waitBusy(0, n);
        check("t4_grant", 32'(grantId[0]), 32'd0);
        hold[0][0] = 1'b1;
        push(0, 3, 8'h70, 1'b0); push(0, 3, 8'h71, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("gap_busy", 32'(busy[0]), 32'd1);
            check("gap_grant", 32'(grantId[0]), 32'd0);
            check("gap_we", 32'(fifoWe[0]), 32'd0);
            tick();
        end
        hold[0][0] = 1'b0;
        waitDone();

        // Reset during beat 2 of a 4-beat burst, then 0 and 2 compete.
        push(0, 1, 8'h90, 1'b0); push(0, 1, 8'h91, 1'b0); push(0, 1, 8'h92, 1'b0); push(0, 1, 8'h93, 1'b1);
        expBeat(0, 1, 8'h90, 1'b0);
        waitBusy(0, n);
        check("t5_grant", 32'(grantId[0]), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        checkIdleOutputs(0, "midburst_reset");
        clearQueues();
        tick();
        tick();
        push(0, 0, 8'hB0, 1'b1); push(0, 2, 8'hD0, 1'b1);
        expBeat(0, 0, 8'hB0, 1'b1); expBeat(0, 2, 8'hD0, 1'b1);
        rst_n = 1'b1;
        waitBusy(0, n);
        check("post_reset_grant", 32'(grantId[0]), 32'd0);
        waitDone();

        // MAX_BURST=1: requesters 1 and 3 alternate one beat per grant.
        push(1, 1, 8'h11, 1'b0); push(1, 1, 8'h12, 1'b0);
        push(1, 3, 8'h31, 1'b0); push(1, 3, 8'h32, 1'b0);
        expBeat(1, 1, 8'h11, 1'b1); expBeat(1, 3, 8'h31, 1'b1);
        expBeat(1, 1, 8'h12, 1'b1); expBeat(1, 3, 8'h32, 1'b1);
        waitDone();

        check("leftover_a", 32'(expQ[0].size()), 32'd0);
        check("leftover_b", 32'(expQ[1].size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
